// File: rtl/stream_upsize_arbiter.sv
// Packet-locked round-robin arbiter feeding one upsizer input through a registered slice.
// Each beat is tagged with its source index, and a per-grant beat limit forces end-of-packet.
module stream_upsize_arbiter #(
  parameter int T_DATA_WIDTH = 1,
  parameter int N_SRC        = 4,
  parameter int MAX_BEATS    = 16,
  parameter int ID_W         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_SRC*T_DATA_WIDTH-1:0] s_data_i,
  input  logic [N_SRC-1:0]              s_last_i,
  input  logic [N_SRC-1:0]              s_valid_i,
  output logic [N_SRC-1:0]              s_ready_o,
  output logic [T_DATA_WIDTH-1:0]       m_data_o,
  output logic                          m_last_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [ID_W-1:0]               m_id_o,
  output logic                          m_trunc_o,
  output logic [N_SRC-1:0]              grant_o
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_nxt;
  logic [ID_W-1:0]         rr_ptr, rr_nxt, g_idx, g_nxt, pick;
  logic                    pick_vld;
  logic [CW-1:0]           beat_cnt, cnt_nxt;
  logic [N_SRC-1:0]        grant_nxt;
  logic                    slot_free, accept, g_last, forced, acc_last;
  logic [T_DATA_WIDTH-1:0] g_data;

  // Scan downward so the lowest offset from rr_ptr is the one that sticks.
  always_comb begin
    logic [ID_W:0] sum;
    sum      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_SRC)) sum = sum - (ID_W+1)'(N_SRC);
      if (s_valid_i[sum[ID_W-1:0]]) begin
        pick     = sum[ID_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int k = 0; k < N_SRC; k++)
      if (g_idx == ID_W'(k)) g_data = s_data_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
  end

  assign slot_free = !m_valid_o || m_ready_i;
  assign s_ready_o = (state == BUSY && slot_free) ? grant_o : '0;
  assign accept    = |(s_valid_i & s_ready_o);
  assign g_last    = |(s_last_i & grant_o);
  assign forced    = (beat_cnt == CNT_LAST) && !g_last;
  assign acc_last  = g_last || forced;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_o;
    g_nxt     = g_idx;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: if (pick_vld) begin
        state_nxt = BUSY;
        grant_nxt = {{(N_SRC-1){1'b0}}, 1'b1} << pick;
        g_nxt     = pick;
        cnt_nxt   = '0;
      end
      BUSY: if (accept) begin
        cnt_nxt = beat_cnt + 1'b1;
        if (acc_last) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          rr_nxt    = (g_idx == ID_W'(N_SRC - 1)) ? '0 : g_idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      grant_o  <= '0;
      g_idx    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_o  <= grant_nxt;
      g_idx    <= g_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // Output slice: loading on the consume cycle keeps one beat per clock.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
      m_trunc_o <= 1'b0;
      m_id_o    <= '0;
    end else if (accept) begin
      m_valid_o <= 1'b1;
      m_data_o  <= g_data;
      m_last_o  <= acc_last;
      m_trunc_o <= forced;
      m_id_o    <= g_idx;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_upsize_arbiter.sv
// Randomized bench for stream_upsize_arbiter: per-source expected beat queues filled at issue,
// and a negedge monitor that checks beats, arbitration order, hold stability and ready rules.
module tb_stream_upsize_arbiter;
  localparam int DW = 8, N = 3, MB = 4, IW = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N*DW-1:0] s_data = '0;
  logic [N-1:0]    s_last = '0, s_valid = '0, s_ready, grant;
  logic [DW-1:0]   m_data;
  logic            m_last, m_valid, m_trunc, m_ready = 1'b0;
  logic [IW-1:0]   m_id;

  always #5 clk = ~clk;

  stream_upsize_arbiter #(.T_DATA_WIDTH(DW), .N_SRC(N), .MAX_BEATS(MB), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_last_i(s_last), .s_valid_i(s_valid),
    .s_ready_o(s_ready), .m_data_o(m_data), .m_last_o(m_last), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .m_id_o(m_id), .m_trunc_o(m_trunc), .grant_o(grant));

  typedef struct packed {logic [DW-1:0] data; logic last; logic trunc;} beat_t;

  beat_t exp_q [N][$];
  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state
  logic [N-1:0] acc = '0, prev_grant = '0;
  int    rr = 0, last_g = 0, arb_exp = 0, cur_id = 0, kk;
  bit    arb_pend = 0, hold = 0, in_pkt = 0, found;
  beat_t held, e;
  logic [IW-1:0] held_id;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < N; k++) exp_q[k].delete();
      rr = 0; arb_pend = 0; prev_grant = '0; hold = 0; in_pkt = 0; acc = '0;
    end else begin
      acc = s_valid & s_ready;
      // Arbitration: first valid source at or after the slot following the last served one.
      if (arb_pend) begin
        check("grant", 32'(grant), 32'(1) << arb_exp);
        arb_pend = 0;
      end
      for (int k = 0; k < N; k++) if (grant[k]) last_g = k;
      if (prev_grant != '0 && grant == '0) rr = (last_g + 1) % N;
      if (grant == '0 && s_valid != '0) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          kk = (rr + i) % N;
          if (!found && s_valid[kk]) begin arb_exp = kk; found = 1; end
        end
        arb_pend = 1;
      end
      prev_grant = grant;

      check("ready_outside_grant", 32'(s_ready & ~grant), 0);
      if (m_valid && !m_ready) check("ready_under_backpressure", 32'(s_ready), 0);

      if (hold) begin
        check("hold_valid", 32'(m_valid), 1);
        check("hold_beat", 32'({m_data, m_last, m_trunc}), 32'(held));
        check("hold_id", 32'(m_id), 32'(held_id));
      end
      hold    = m_valid && !m_ready;
      held    = {m_data, m_last, m_trunc};
      held_id = m_id;

      if (m_valid && m_ready) begin
        if (in_pkt) check("interleave_id", 32'(m_id), 32'(cur_id));
        if (m_id >= N || exp_q[m_id].size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_beat: got id %0d data %0h with no expected beat", m_id, m_data);
        end else begin
          e = exp_q[m_id].pop_front();
          check("beat", 32'({m_data, m_last, m_trunc}), 32'(e));
        end
        in_pkt = !m_last;
        cur_id = m_id;
      end
    end
  end

  // Source model: beats are chunked into grants of at most MB, last forced at the limit.
  int rem [N], cpos [N];

  task automatic step_sources(input int rate, input int fixed_len, input logic [N-1:0] mask,
                              input bit active);
    logic [DW-1:0] d;
    bit f;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) s_valid[k] = 1'b0;
      if (!s_valid[k] && (rem[k] != 0 || (active && mask[k])) && $urandom_range(0, 99) < rate) begin
        if (rem[k] == 0) rem[k] = (fixed_len > 0) ? fixed_len : $urandom_range(1, 9);
        d = DW'($urandom);
        s_data[k*DW +: DW] = d;
        s_last[k] = (rem[k] == 1);
        rem[k]--;
        f = (cpos[k] == MB - 1) && !s_last[k];
        exp_q[k].push_back({d, s_last[k] || f, f});
        cpos[k] = (s_last[k] || f) ? 0 : cpos[k] + 1;
        s_valid[k] = 1'b1;
      end
    end
  endtask

  task automatic run(input int cycles, input int rate, input int fixed_len,
                     input logic [N-1:0] mask, input int rdy_pct);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      step_sources(rate, fixed_len, mask, 1'b1);
      m_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_m_valid"}, 32'(m_valid), 0);
    check({tag, "_m_data"}, 32'(m_data), 0);
    check({tag, "_m_last"}, 32'(m_last), 0);
    check({tag, "_m_id"}, 32'(m_id), 0);
    check({tag, "_m_trunc"}, 32'(m_trunc), 0);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
  endtask

  initial begin
    bit hit, done;
    int total;
    for (int k = 0; k < N; k++) begin rem[k] = 0; cpos[k] = 0; end
    #2 rst_n = 1'b1;
    #1 check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;

    run(30, 100, 3, 3'b100, 100);   // single source, full throughput
    run(1500, 40, 0, 3'b111, 70);   // mixed traffic, long packets get truncated
    run(300, 60, 0, 3'b111, 30);    // heavy backpressure
    run(200, 100, 2, 3'b111, 100);  // all sources saturated: strict rotation

    // Async reset while a beat is held mid-packet
    hit = 0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(posedge clk); #1;
      step_sources(80, 6, 3'b111, 1'b1);
      m_ready = 1'b0;
      hit = (grant != '0) && m_valid;
    end
    if (!hit) begin
      n_cmp++; n_err++;
      $display("FAIL reset_setup: no busy state with held beat within budget");
    end
    #2 rst_n = 1'b1;
    #1 check_zero_outputs("midreset");
    s_valid = '0; s_last = '0;
    for (int k = 0; k < N; k++) begin rem[k] = 0; cpos[k] = 0; end
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;

    run(500, 50, 0, 3'b111, 60);

    // Drain: finish open packets, start no new ones
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #1;
      step_sources(100, 0, 3'b111, 1'b0);
      m_ready = 1'b1;
      done = 1;
      for (int k = 0; k < N; k++) if (rem[k] != 0) done = 0;
      if (s_valid != '0 || m_valid) done = 0;
    end
    @(negedge clk); @(negedge clk);
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: traffic still pending after budget");
    end
    total = 0;
    for (int k = 0; k < N; k++) total += exp_q[k].size();
    check("drain_leftover_beats", 32'(total), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stream_upsize_arbiter.md
Name: stream_upsize_arbiter

Overview:
Packet-level round-robin arbiter that shares one stream upsizer input between N_SRC narrow requester streams. It locks the grant to one source from its first beat to its last beat, so packets are never interleaved. Accepted beats go through a registered output slice that feeds the upsizer's s_* port and is tagged with the source index. A per-packet beat limit forces a last flag so that one requester cannot hold the upsizer indefinitely.

Parameters:
T_DATA_WIDTH, 1, width of one narrow beat (matches upsizer T_DATA_WIDTH)
N_SRC, 4, number of requester streams (2..16)
MAX_BEATS, 16, maximum beats per granted packet before a forced last (>=1)
ID_W, $clog2(N_SRC) (min 1), width of source tag

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-high
s_data_i  in  N_SRC*T_DATA_WIDTH  source beats; source k occupies bits [k*T_DATA_WIDTH +: T_DATA_WIDTH]
s_last_i  in  N_SRC  per-source end-of-packet
s_valid_i  in  N_SRC  per-source valid
s_ready_o  out  N_SRC  per-source ready (combinational)
m_data_o  out  T_DATA_WIDTH  registered beat to upsizer
m_last_o  out  1  registered last (source last or forced)
m_valid_o  out  1  registered valid
m_ready_i  in  1  upsizer ready
m_id_o  out  ID_W  source index of the current m_* beat
m_trunc_o  out  1  high with a beat whose last was forced by MAX_BEATS
grant_o  out  N_SRC  one-hot current grant (0 in IDLE)

Behaviour:
- Reset (rst_n=1, async): state=IDLE, rr_ptr=0, grant_o=0, beat_cnt=0, m_valid_o=0, m_data_o=0, m_last_o=0, m_id_o=0, m_trunc_o=0. Reset mid-packet discards the held beat and the grant.
- FSM states: IDLE, BUSY.
- IDLE: s_ready_o=0. If any s_valid_i bit is set, pick the first set bit scanning upward from rr_ptr with wrap (k = rr_ptr, rr_ptr+1, ... mod N_SRC). Next cycle: grant_o=onehot(k), state=BUSY, beat_cnt=0. Arbitration costs one cycle; there is a one-cycle bubble between packets.
- BUSY: s_ready_o[g] = !m_valid_o || m_ready_i for the granted index g. All other bits are 0. Bits of s_valid_i for non-granted sources are ignored.
- Accept occurs when s_valid_i[g] && s_ready_o[g]. On accept: m_data_o=source g data, m_valid_o=1, m_id_o=g, forced=(beat_cnt==MAX_BEATS-1)&&!s_last_i[g], m_last_o=s_last_i[g]||forced, m_trunc_o=forced, beat_cnt++.
- If the accepted beat has m_last_o=1, then in the same edge: state=IDLE, grant_o=0, rr_ptr=(g+1) mod N_SRC.
- Output slice: if m_valid_o && !m_ready_i, all m_* outputs hold stable. If m_ready_i && no accept, then m_valid_o=0 next cycle, and m_data_o/m_last_o/m_trunc_o are don't-care. Accepting on the same cycle the upsizer consumes a beat gives full throughput, 1 beat/cycle within a packet.
- Forced last: later beats of the truncated packet are re-arbitrated as a new packet from that source. Because rr_ptr advances past it, other pending sources are served first.
- Idle sources: if the granted source deasserts valid mid-packet, the grant is still held. No timeout.
- MAX_BEATS=1: every beat is a packet; each beat has m_last_o=1. m_trunc_o=1 unless s_last_i was set.
- Widths: beat_cnt is $clog2(MAX_BEATS+1) bits and never exceeds MAX_BEATS-1 at compare. rr_ptr is ID_W bits, and wrap is explicit for non-power-of-2 N_SRC.

Test Plan:
- Single source: N_SRC=4, src2 sends 3 beats 0xA,0xB,0xC with last on C, m_ready_i=1 -> grant_o=4'b0100 one cycle after valid. m_data A,B,C on consecutive cycles, m_id_o=2, m_last_o only on C, then IDLE with rr_ptr=3.
- Round robin fairness: all 4 sources continuously offer 2-beat packets -> packet order 0,1,2,3,0,... and no interleaving within a packet.
- Backpressure: m_ready_i low for 3 cycles mid-packet -> m_data_o/m_last_o/m_id_o stable and s_ready_o[g]=0 while m_valid_o=1. No beat is lost or duplicated.
- Forced last: MAX_BEATS=4, src1 sends 6-beat packet while src3 is pending -> beat 4 has m_last_o=1 and m_trunc_o=1. src3 packet follows, then src1's remaining 2 beats with the last on beat 6.
- Wrap with non-power-of-2: N_SRC=3, rr_ptr=2, sources 0 and 1 valid -> source 0 granted next.
- Async reset mid-packet: assert rst_n while BUSY with m_valid_o=1 -> all outputs 0 immediately, and arbitration restarts from rr_ptr=0 after release.
